stopwatch_ctrl: RTL and testbench

Control unit for the stopwatch datapath. It debounces the run/stop, clear and mode push-buttons and converts each press into a single-cycle event. A Moore state machine then drives the datapath's `run_stop`, `clear` and `option` inputs. The block sits between the board buttons and the stopwatch datapath, and all of its outputs are registered.

---
 rtl/stopwatch_ctrl.sv | 161 ++++++++++++++++
 tb/tb_stopwatch_ctrl.sv | 261 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/stopwatch_ctrl.sv
`default_nettype none
// ============================================================================
//  Module   : stopwatch_ctrl
//  Brief    : Button front end and Moore FSM driving the stopwatch datapath.
//             Three raw buttons are synchronized, debounced on a slow sample
//             tick and reduced to single-cycle press events; the FSM turns
//             those events into run_stop / clear, and a toggle flop drives
//             the display option.
//  Config   : STOPWATCH_LAP_EN adds btn_lap / lap_hold (lap freeze in RUN).
//  Revision : 1.0 - initial release
// ============================================================================
module stopwatch_ctrl #(
  parameter int DB_DIV = 100_000,
  parameter int DB_LEN = 8
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       btn_run,
  input  logic       btn_clear,
  input  logic       btn_mode,
`ifdef STOPWATCH_LAP_EN
  input  logic       btn_lap,
  output logic       lap_hold,
`endif
  output logic       run_stop,
  output logic       clear,
  output logic       option,
  output logic [1:0] state_o
);

  localparam int IDX_RUN  = 0;
  localparam int IDX_CLR  = 1;
  localparam int IDX_MODE = 2;
`ifdef STOPWATCH_LAP_EN
  localparam int IDX_LAP  = 3;
  localparam int NB       = 4;
`else
  localparam int NB       = 3;
`endif
  localparam int CW = (DB_DIV > 1) ? $clog2(DB_DIV) : 1;

  typedef enum logic [1:0] {
    ST_STOP  = 2'd0,
    ST_RUN   = 2'd1,
    ST_CLEAR = 2'd2
  } state_t;

  logic [NB-1:0] w_btn;
`ifdef STOPWATCH_LAP_EN
  assign w_btn = {btn_lap, btn_mode, btn_clear, btn_run};
`else
  assign w_btn = {btn_mode, btn_clear, btn_run};
`endif

  logic [NB-1:0] sync1_q, sync2_q;
  logic [CW-1:0] pre_q;
  logic          w_smp;
  logic [NB-1:0] w_db;
  logic [NB-1:0] db_dly_q;
  logic [NB-1:0] w_ev;
  state_t        state_q, state_d;
  logic          option_q;

  // Two-flop synchronizer for every raw button.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sync1_q <= '0;
      sync2_q <= '0;
    end else begin
      sync1_q <= w_btn;
      sync2_q <= sync1_q;
    end
  end

  assign w_smp = (pre_q == CW'(DB_DIV - 1));

  // Sample-tick prescaler: counts 0..DB_DIV-1 and wraps.
  always_ff @(posedge clk or posedge rst) begin
    if (rst)        pre_q <= '0;
    else if (w_smp) pre_q <= '0;
    else            pre_q <= pre_q + 1'b1;
  end

  // Per-button debounce; the level decision is taken on a tick from the
  // history as it stood before that tick's shift.
  for (genvar i = 0; i < NB; i++) begin : g_db
    logic [DB_LEN-1:0] hist_q;
    logic              db_q;

    // Shift history and update the debounced level on each sample tick.
    always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
        hist_q <= '0;
        db_q   <= 1'b0;
      end else if (w_smp) begin
        hist_q <= {hist_q[DB_LEN-2:0], sync2_q[i]};
        if (&hist_q)       db_q <= 1'b1;
        else if (~|hist_q) db_q <= 1'b0;
      end
    end

    assign w_db[i] = db_q;
  end

  // Delayed debounced levels for rising-edge (press) detection.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) db_dly_q <= '0;
    else     db_dly_q <= w_db;
  end

  assign w_ev = w_db & ~db_dly_q;

  // FSM state register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state_q <= ST_STOP;
    else     state_q <= state_d;
  end

  // Next-state logic: clear beats run in STOP, clear ignored in RUN,
  // CLEAR lasts one cycle and drops anything arriving meanwhile.
  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_STOP: begin
        if (w_ev[IDX_CLR])      state_d = ST_CLEAR;
        else if (w_ev[IDX_RUN]) state_d = ST_RUN;
      end
      ST_RUN: begin
        if (w_ev[IDX_RUN])      state_d = ST_STOP;
      end
      ST_CLEAR:                 state_d = ST_STOP;
      default:                  state_d = ST_STOP;
    endcase
  end

  // Display option toggles on every mode press regardless of FSM state.
  always_ff @(posedge clk or posedge rst) begin
    if (rst)                 option_q <= 1'b0;
    else if (w_ev[IDX_MODE]) option_q <= ~option_q;
  end

`ifdef STOPWATCH_LAP_EN
  logic lap_hold_q;

  // Lap freeze toggles only while running; outside RUN (STOP, CLEAR) it is 0.
  always_ff @(posedge clk or posedge rst) begin
    if (rst)                     lap_hold_q <= 1'b0;
    else if (state_q != ST_RUN)  lap_hold_q <= 1'b0;
    else if (w_ev[IDX_LAP])      lap_hold_q <= ~lap_hold_q;
  end

  assign lap_hold = lap_hold_q;
`endif

  assign run_stop = (state_q == ST_RUN);
  assign clear    = (state_q == ST_CLEAR);
  assign option   = option_q;
  assign state_o  = state_q;

endmodule
`default_nettype wire

// File: tb/tb_stopwatch_ctrl.sv
`default_nettype none
// ============================================================================
//  Module   : tb_stopwatch_ctrl
//  Brief    : Self-checking bench for stopwatch_ctrl (DB_DIV=4, DB_LEN=3).
//             Table of settled button steps plus directed corner sequences.
//             Build with STOPWATCH_LAP_EN to include the lap sequence.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_stopwatch_ctrl;

  localparam int DB_DIV = 4;
  localparam int DB_LEN = 3;
  localparam int SETTLE = 30;
  localparam int NVEC   = 17;

  logic       clk = 1'b0;
  logic       rst;
  logic       btn_run, btn_clear, btn_mode;
  logic       run_stop, clear, option;
  logic [1:0] state_o;
`ifdef STOPWATCH_LAP_EN
  logic       btn_lap;
  logic       lap_hold;
`endif

  always #5 clk = ~clk;

  stopwatch_ctrl #(.DB_DIV(DB_DIV), .DB_LEN(DB_LEN)) dut (
    .clk       (clk),
    .rst       (rst),
    .btn_run   (btn_run),
    .btn_clear (btn_clear),
    .btn_mode  (btn_mode),
`ifdef STOPWATCH_LAP_EN
    .btn_lap   (btn_lap),
    .lap_hold  (lap_hold),
`endif
    .run_stop  (run_stop),
    .clear     (clear),
    .option    (option),
    .state_o   (state_o)
  );

  int n_applied     = 0;
  int n_miscompares = 0;

  task automatic check(input string name, input int act, input int exp);
    n_applied++;
    if (act != exp) begin
      n_miscompares++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  task automatic check_range(input string name, input int act, input int lo, input int hi);
    n_applied++;
    if (act < lo || act > hi) begin
      n_miscompares++;
      $display("FAIL %s: got %0d, expected %0d..%0d", name, act, lo, hi);
    end
  endtask

  task automatic cyc(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic set_btn(input logic r, input logic c, input logic m);
    btn_run   = r;
    btn_clear = c;
    btn_mode  = m;
  endtask

  // Output monitor, sampled on the falling edge.
  int   rs_rise = 0, rs_fall = 0;
  int   clr_pulses = 0, clr_bad_width = 0, clr_overlap = 0, post_clr_bad = 0;
  int   clr_run = 0;
  logic rs_prev = 1'b0, clr_prev = 1'b0;

  always @(negedge clk) begin
    if (rst) begin
      rs_prev  = 1'b0;
      clr_prev = 1'b0;
      clr_run  = 0;
    end else begin
      if (run_stop && !rs_prev) rs_rise++;
      if (!run_stop && rs_prev) rs_fall++;
      if (clear && run_stop) clr_overlap++;
      if (clear) clr_run++;
      else if (clr_run != 0) begin
        clr_pulses++;
        if (clr_run != 1) clr_bad_width++;
        clr_run = 0;
      end
      if (clr_prev && !clear && state_o != 2'd0) post_clr_bad++;
      rs_prev  = run_stop;
      clr_prev = clear;
    end
  end

  typedef struct packed {
    logic       r, c, m;
    logic       exp_rs, exp_opt;
    logic [1:0] exp_st;
  } vec_t;

  vec_t tbl [NVEC];

  initial begin
    int lat, base_r, base_f, base_p;

    tbl[0]  = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 2'd0};
    tbl[1]  = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 2'd1};  // start
    tbl[2]  = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 2'd1};  // release: no event
    tbl[3]  = '{1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 2'd1};  // clear ignored in RUN
    tbl[4]  = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 2'd1};
    tbl[5]  = '{1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 2'd1};  // mode in RUN
    tbl[6]  = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 2'd1};
    tbl[7]  = '{1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 2'd0};  // stop
    tbl[8]  = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 2'd0};
    tbl[9]  = '{1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 2'd0};  // mode in STOP
    tbl[10] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 2'd0};
    tbl[11] = '{1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 2'd0};  // clear from STOP
    tbl[12] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 2'd0};
    tbl[13] = '{1'b1, 1'b0, 1'b1, 1'b1, 1'b1, 2'd1};  // run + mode together
    tbl[14] = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 2'd1};
    tbl[15] = '{1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 2'd0};  // stop
    tbl[16] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 2'd0};

    rst = 1'b1;
    set_btn(1'b0, 1'b0, 1'b0);
`ifdef STOPWATCH_LAP_EN
    btn_lap = 1'b0;
`endif
    #2;
    check("reset_run_stop", run_stop, 0);
    check("reset_clear",    clear,    0);
    check("reset_option",   option,   0);
    check("reset_state",    state_o,  0);
    cyc(3);
    rst = 1'b0;

    // Table of settled steps.
    for (int i = 0; i < NVEC; i++) begin
      set_btn(tbl[i].r, tbl[i].c, tbl[i].m);
      cyc(SETTLE);
      check($sformatf("vec%0d_run_stop", i), run_stop, tbl[i].exp_rs);
      check($sformatf("vec%0d_clear",    i), clear,    0);
      check($sformatf("vec%0d_option",   i), option,   tbl[i].exp_opt);
      check($sformatf("vec%0d_state",    i), state_o,  tbl[i].exp_st);
    end
    check("table_clear_pulses", clr_pulses, 1);

    // Asynchronous reset in the middle of a run with buttons active.
    set_btn(1'b1, 1'b0, 1'b0);
    cyc(SETTLE);
    check("pre_reset_running", run_stop, 1);
    #2 rst = 1'b1;
    #1;
    check("async_rst_run_stop", run_stop, 0);
    check("async_rst_clear",    clear,    0);
    check("async_rst_option",   option,   0);
    check("async_rst_state",    state_o,  0);
    for (int i = 0; i < 6; i++) begin
      set_btn(i[0], ~i[0], i[1]);
      cyc(1);
    end
    check("held_rst_run_stop", run_stop, 0);
    check("held_rst_option",   option,   0);
    set_btn(1'b0, 1'b0, 1'b0);
    rst = 1'b0;
    cyc(SETTLE);
    check("post_rst_state", state_o, 0);

    // Run/stop press latency and single event per hold.
    base_r = rs_rise;
    base_f = rs_fall;
    set_btn(1'b1, 1'b0, 1'b0);
    lat = 0;
    for (int n = 1; n <= 40; n++) begin
      cyc(1);
      if (run_stop && lat == 0) lat = n;
    end
    check_range("run_rise_latency", lat, 16, 19);
    set_btn(1'b0, 1'b0, 1'b0);
    cyc(40);
    check("run_still_running", run_stop, 1);
    check("run_single_rise", rs_rise - base_r, 1);
    set_btn(1'b1, 1'b0, 1'b0);
    lat = 0;
    for (int n = 1; n <= 40; n++) begin
      cyc(1);
      if (!run_stop && lat == 0) lat = n;
    end
    check_range("run_fall_latency", lat, 16, 19);
    set_btn(1'b0, 1'b0, 1'b0);
    cyc(SETTLE);
    check("run_single_fall", rs_fall - base_f, 1);

    // Bounce: toggling every 5 clk never fills the history.
    base_r = rs_rise;
    for (int i = 0; i < 12; i++) begin
      btn_run = ~i[0];
      cyc(5);
    end
    btn_run = 1'b0;
    cyc(SETTLE);
    check("bounce_no_rise", rs_rise - base_r, 0);
    check("bounce_run_stop", run_stop, 0);

    // Simultaneous run + clear in STOP: clear wins.
    base_r = rs_rise;
    base_p = clr_pulses;
    set_btn(1'b1, 1'b1, 1'b0);
    cyc(SETTLE);
    set_btn(1'b0, 1'b0, 1'b0);
    cyc(SETTLE);
    check("simul_clear_pulse", clr_pulses - base_p, 1);
    check("simul_no_run",      rs_rise - base_r,    0);
    check("simul_state",       state_o,             0);

    // Clear from STOP once more.
    base_p = clr_pulses;
    set_btn(1'b0, 1'b1, 1'b0);
    cyc(SETTLE);
    set_btn(1'b0, 1'b0, 1'b0);
    cyc(SETTLE);
    check("stop_clear_pulse", clr_pulses - base_p, 1);

`ifdef STOPWATCH_LAP_EN
    set_btn(1'b1, 1'b0, 1'b0);
    cyc(SETTLE);
    set_btn(1'b0, 1'b0, 1'b0);
    cyc(SETTLE);
    check("lap_initial", lap_hold, 0);
    btn_lap = 1'b1;
    cyc(SETTLE);
    btn_lap = 1'b0;
    cyc(SETTLE);
    check("lap_set_in_run", lap_hold, 1);
    set_btn(1'b1, 1'b0, 1'b0);
    cyc(SETTLE);
    set_btn(1'b0, 1'b1, 1'b0);
    cyc(SETTLE);
    set_btn(1'b0, 1'b0, 1'b0);
    cyc(SETTLE);
    check("lap_after_clear", lap_hold, 0);
`endif

    check("clear_width_errors",   clr_bad_width, 0);
    check("clear_with_run",       clr_overlap,   0);
    check("state_after_clear",    post_clr_bad,  0);

    $display("== %0d vectors applied, %0d miscompares ==", n_applied, n_miscompares);
    $finish;
  end

endmodule
`default_nettype wire
